rv32v_mem_uop_sequencer: RTL and testbench

Breaks one vector load/store instruction into per-uop lane batches and drives the vector memory serializer's latch side. One uop covers `NUM_LANES` elements. For each uop the block fetches mask, index and store-data operands, computes lane addresses and masks, launches the serializer, and waits for it to finish. It sits between vector issue and the serializer, and owns the serializer's global and per-lane latch inputs.

---
 rtl/rv32v_types_pkg.sv | 30 +++
 rtl/rv32v_lane_addr_gen.sv | 51 +++++
 rtl/rv32v_mem_uop_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_rv32v_mem_uop_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// rtl/rv32v_types_pkg.sv - shared vector types for the memory uop sequencer
package rv32v_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    VSEW_8    = 2'b00,
    VSEW_16   = 2'b01,
    VSEW_32   = 2'b10,
    VSEW_RSVD = 2'b11
  } vsew_t;

  typedef enum logic [1:0] {
    VMEM_UNIT    = 2'b00,
    VMEM_STRIDED = 2'b01,
    VMEM_INDEXED = 2'b10,
    VMEM_RSVD    = 2'b11
  } vmem_mode_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FETCH = 3'd1,
    SEQ_ISSUE = 3'd2,
    SEQ_WAIT  = 3'd3,
    SEQ_DONE  = 3'd4
  } vmem_seq_state_t;

  localparam int UOP_NUM_W = 5;

endpackage

// File: rtl/rv32v_lane_addr_gen.sv
// rtl/rv32v_lane_addr_gen.sv - combinational per-lane address and mask generation
module rv32v_lane_addr_gen
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int VLE_W     = 7
) (
  input  vmem_mode_t                 mode_i,
  input  vsew_t                      veew_i,
  input  word_t                      base_i,
  input  word_t                      stride_i,
  input  logic [UOP_NUM_W-1:0]       k_i,
  input  logic [NUM_LANES*32-1:0]    index_i,
  input  logic [VLE_W-1:0]           vl_i,
  input  logic                       vm_i,
  input  logic [NUM_LANES-1:0]       v0_i,
  output logic [NUM_LANES*32-1:0]    addr_o,
  output logic [NUM_LANES-1:0]       mask_o
);

  localparam int LANE_SH = $clog2(NUM_LANES);

  word_t elem;
  word_t idx;
  word_t lane_addr;

  always_comb begin
    addr_o    = '0;
    mask_o    = '0;
    elem      = '0;
    idx       = '0;
    lane_addr = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      // NUM_LANES is a power of two, so the lane number fills the low bits
      elem = (word_t'(k_i) << LANE_SH) | word_t'(l);
      case (veew_i)
        VSEW_8:  idx = {24'b0, index_i[l*32 +: 8]};
        VSEW_16: idx = {16'b0, index_i[l*32 +: 16]};
        default: idx = index_i[l*32 +: 32];
      endcase
      case (mode_i)
        VMEM_STRIDED: lane_addr = base_i + elem * stride_i;
        VMEM_INDEXED: lane_addr = base_i + idx;
        default:      lane_addr = base_i + (elem << veew_i);
      endcase
      addr_o[l*32 +: 32] = lane_addr;
      mask_o[l]          = (elem < word_t'(vl_i)) && (vm_i || v0_i[l]);
    end
  end

endmodule

// File: rtl/rv32v_mem_uop_sequencer.sv
// rtl/rv32v_mem_uop_sequencer.sv - splits a vector load/store into lane-batch uops for the serializer
module rv32v_mem_uop_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int VL_W      = 7
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic                       issue_load,
  input  vmem_mode_t                 issue_mode,
  input  vsew_t                      issue_veew,
  input  word_t                      issue_base,
  input  word_t                      issue_stride,
  input  logic [VL_W-1:0]            issue_vl,
  input  logic                       issue_vm,
  output logic                       opnd_req,
  output logic [UOP_NUM_W-1:0]       opnd_uop,
  input  logic                       opnd_valid,
  input  logic [NUM_LANES-1:0]       opnd_v0,
  input  logic [NUM_LANES*32-1:0]    opnd_index,
  input  logic [NUM_LANES*32-1:0]    opnd_data,
  input  logic                       ser_ready,
  output logic                       ser_start,
  input  logic                       ser_done,
  output logic                       vmemdwen,
  output logic                       vmemdren,
  output logic [UOP_NUM_W-1:0]       vuop_num,
  output logic                       vindexed,
  output word_t                      base,
  output word_t                      stride,
  output vsew_t                      veew,
  output logic [NUM_LANES-1:0]       vlane_mask,
  output logic [NUM_LANES*32-1:0]    vlane_addr,
  output logic [NUM_LANES*32-1:0]    vlane_store_data,
  output logic                       strided,
  output logic                       unit_strided,
  output logic                       vnew_seg,
  output logic                       vseg_op,
  output logic                       busy,
  output logic                       done
);

  localparam int LANE_SH = $clog2(NUM_LANES);
  localparam int MAX_VL  = 32 * NUM_LANES;
  localparam int VLE_W   = $clog2(MAX_VL + 1);

  vmem_seq_state_t state_q, state_d;
  logic [UOP_NUM_W-1:0] k_q, k_d, last_k_q;
  logic [VLE_W-1:0]     vl_q;
  logic                 vm_q;
  vmem_mode_t           mode_q;
  vsew_t                veew_q;
  word_t                base_q, stride_q;
  logic                 dren_q, dwen_q, indexed_q, strided_q, unit_q;
  logic [NUM_LANES-1:0]    mask_q;
  logic [NUM_LANES*32-1:0] addr_q, data_q;

  logic                    accept, lanes_ld, last_uop;
  logic [VLE_W-1:0]        eff_vl;
  logic [UOP_NUM_W-1:0]    eff_last_k;
  vmem_mode_t              mode_norm;
  logic [NUM_LANES*32-1:0] gen_addr;
  logic [NUM_LANES-1:0]    gen_mask;

  always_comb begin
    eff_vl     = (word_t'(issue_vl) > word_t'(MAX_VL)) ? VLE_W'(MAX_VL) : VLE_W'(issue_vl);
    eff_last_k = UOP_NUM_W'((word_t'(eff_vl) - 32'd1) >> LANE_SH);
    mode_norm  = (issue_mode == VMEM_RSVD) ? VMEM_UNIT : issue_mode;
  end

  assign last_uop = (k_q == last_k_q);

  rv32v_lane_addr_gen #(
    .NUM_LANES (NUM_LANES),
    .VLE_W     (VLE_W)
  ) u_lane_addr_gen (
    .mode_i   (mode_q),
    .veew_i   (veew_q),
    .base_i   (base_q),
    .stride_i (stride_q),
    .k_i      (k_q),
    .index_i  (opnd_index),
    .vl_i     (vl_q),
    .vm_i     (vm_q),
    .v0_i     (opnd_v0),
    .addr_o   (gen_addr),
    .mask_o   (gen_mask)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    accept      = 1'b0;
    lanes_ld    = 1'b0;
    issue_ready = 1'b0;
    opnd_req    = 1'b0;
    ser_start   = 1'b0;
    done        = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        issue_ready = ~flush;
        if (issue_valid) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = (eff_vl == '0) ? SEQ_DONE : SEQ_FETCH;
        end
      end
      SEQ_FETCH: begin
        opnd_req = 1'b1;
        if (opnd_valid) begin
          lanes_ld = 1'b1;
          state_d  = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (mask_q == '0) begin
          if (last_uop) begin
            state_d = SEQ_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = SEQ_FETCH;
          end
        end else if (ser_ready) begin
          ser_start = 1'b1;
          state_d   = SEQ_WAIT;
        end
      end
      SEQ_WAIT: begin
        if (ser_done) begin
          if (last_uop) begin
            state_d = SEQ_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = SEQ_FETCH;
          end
        end
      end
      SEQ_DONE: begin
        done    = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
    // abort overrides every transition and squashes the side-effect pulses
    if (flush) begin
      state_d   = SEQ_IDLE;
      k_d       = '0;
      accept    = 1'b0;
      lanes_ld  = 1'b0;
      ser_start = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= SEQ_IDLE;
      k_q       <= '0;
      last_k_q  <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      mode_q    <= VMEM_UNIT;
      veew_q    <= VSEW_8;
      base_q    <= '0;
      stride_q  <= '0;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      indexed_q <= 1'b0;
      strided_q <= 1'b0;
      unit_q    <= 1'b0;
      mask_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        last_k_q  <= eff_last_k;
        vl_q      <= eff_vl;
        vm_q      <= issue_vm;
        mode_q    <= mode_norm;
        veew_q    <= issue_veew;
        base_q    <= issue_base;
        stride_q  <= issue_stride;
        dren_q    <= issue_load;
        dwen_q    <= ~issue_load;
        indexed_q <= (mode_norm == VMEM_INDEXED);
        strided_q <= (mode_norm == VMEM_STRIDED);
        unit_q    <= (mode_norm == VMEM_UNIT);
      end
      if (lanes_ld) begin
        mask_q <= gen_mask;
        addr_q <= gen_addr;
        data_q <= opnd_data;
      end
    end
  end

  assign opnd_uop         = k_q;
  assign busy             = (state_q != SEQ_IDLE);
  assign vmemdren         = dren_q;
  assign vmemdwen         = dwen_q;
  assign vuop_num         = k_q;
  assign vindexed         = indexed_q;
  assign strided          = strided_q;
  assign unit_strided     = unit_q;
  assign base             = base_q;
  assign stride           = stride_q;
  assign veew             = veew_q;
  assign vlane_mask       = mask_q;
  assign vlane_addr       = addr_q;
  assign vlane_store_data = data_q;
  assign vnew_seg         = 1'b0;
  assign vseg_op          = 1'b0;

endmodule

// File: tb/tb_rv32v_mem_uop_sequencer.sv
// tb/tb_rv32v_mem_uop_sequencer.sv - self-checking bench for the vector memory uop sequencer
module tb_rv32v_mem_uop_sequencer;
  import rv32v_types_pkg::*;

  localparam int NL = 2;

  logic        CLK = 1'b0;
  logic        RST, flush, issue_valid, issue_ready, issue_load, issue_vm;
  vmem_mode_t  issue_mode;
  vsew_t       issue_veew;
  logic [31:0] issue_base, issue_stride;
  logic [6:0]  issue_vl;
  logic        opnd_req, opnd_valid;
  logic [4:0]  opnd_uop;
  logic [NL-1:0]    opnd_v0;
  logic [NL*32-1:0] opnd_index, opnd_data;
  logic        ser_ready, ser_start, ser_done;
  logic        vmemdwen, vmemdren, vindexed, strided, unit_strided, vnew_seg, vseg_op, busy, done;
  logic [4:0]  vuop_num;
  logic [31:0] base, stride;
  vsew_t       veew;
  logic [NL-1:0]    vlane_mask;
  logic [NL*32-1:0] vlane_addr, vlane_store_data;

  rv32v_mem_uop_sequencer #(.NUM_LANES(NL), .VL_W(7)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_load(issue_load),
    .issue_mode(issue_mode), .issue_veew(issue_veew), .issue_base(issue_base),
    .issue_stride(issue_stride), .issue_vl(issue_vl), .issue_vm(issue_vm),
    .opnd_req(opnd_req), .opnd_uop(opnd_uop), .opnd_valid(opnd_valid),
    .opnd_v0(opnd_v0), .opnd_index(opnd_index), .opnd_data(opnd_data),
    .ser_ready(ser_ready), .ser_start(ser_start), .ser_done(ser_done),
    .vmemdwen(vmemdwen), .vmemdren(vmemdren), .vuop_num(vuop_num), .vindexed(vindexed),
    .base(base), .stride(stride), .veew(veew), .vlane_mask(vlane_mask),
    .vlane_addr(vlane_addr), .vlane_store_data(vlane_store_data),
    .strided(strided), .unit_strided(unit_strided), .vnew_seg(vnew_seg),
    .vseg_op(vseg_op), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [NL-1:0]    v0_a  [32];
  logic [NL*32-1:0] idx_a [32];
  logic [NL*32-1:0] dat_a [32];
  int last_nstart, last_first_start, last_done_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_addr(input int mode, input int eew, input logic [31:0] b,
                                           input logic [31:0] s, input logic [31:0] idx, input int e);
    logic [31:0] off;
    case (mode)
      1: return b + s * 32'(e);
      2: begin
        off = (eew == 0) ? idx % 32'd256 : (eew == 1) ? idx % 32'd65536 : idx;
        return b + off;
      end
      default: return b + 32'(e) * (32'd1 << eew);
    endcase
  endfunction

  task automatic run_instr(input string tag, input bit ld, input int mode, input int eew,
                           input logic [31:0] b, input logic [31:0] s, input int vl, input bit vm,
                           input int rdy_delay, input bit abort);
    int evl, nu, fetch_idx, rcnt, dtimer, nstart, ndone;
    bit fin, m;
    logic [NL-1:0]    em;
    logic [NL*32-1:0] ea;
    int               eq_k [$];
    logic [NL-1:0]    eq_m [$];
    logic [NL*32-1:0] eq_a [$];
    evl = (vl > 32 * NL) ? 32 * NL : vl;
    nu  = (evl + NL - 1) / NL;
    for (int k = 0; k < nu; k++) begin
      em = '0;
      for (int l = 0; l < NL; l++) begin
        m = ((k * NL + l) < evl) && (vm || v0_a[k][l]);
        em[l] = m;
        ea[l*32 +: 32] = mdl_addr(mode, eew, b, s, idx_a[k][l*32 +: 32], k * NL + l);
      end
      if (em != '0) begin
        eq_k.push_back(k);
        eq_m.push_back(em);
        eq_a.push_back(ea);
      end
    end
    @(negedge CLK);
    issue_valid = 1'b1; issue_load = ld; issue_mode = vmem_mode_t'(mode);
    issue_veew = vsew_t'(eew); issue_base = b; issue_stride = s; issue_vl = 7'(vl); issue_vm = vm;
    #1 chk({tag, " issue_ready"}, 64'(issue_ready), 64'd1);
    fetch_idx = 0; rcnt = 0; dtimer = 0; nstart = 0; ndone = 0; fin = 0;
    last_first_start = -1; last_done_cyc = -1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge CLK);
      issue_valid = 1'b0;
      flush = 1'b0;
      opnd_valid = opnd_req;
      if (opnd_req) begin
        chk({tag, " opnd_uop"}, 64'(opnd_uop), 64'(fetch_idx));
        fetch_idx++;
        opnd_v0 = v0_a[opnd_uop]; opnd_index = idx_a[opnd_uop]; opnd_data = dat_a[opnd_uop];
      end
      ser_done = 1'b0;
      if (dtimer > 0) begin
        dtimer--;
        if (dtimer == 0) ser_done = 1'b1;
      end
      ser_ready = (rcnt >= rdy_delay);
      rcnt++;
      #1;
      if (ser_start) begin
        nstart++;
        if (last_first_start < 0) last_first_start = cyc;
        chk({tag, " start_when_ready"}, 64'(ser_ready), 64'd1);
        if (eq_k.size() == 0) begin
          chk({tag, " unexpected_start"}, 64'd1, 64'd0);
        end else begin
          chk({tag, " vuop_num"}, 64'(vuop_num), 64'(eq_k[0]));
          chk({tag, " vlane_mask"}, 64'(vlane_mask), 64'(eq_m.pop_front()));
          chk({tag, " vlane_addr"}, 64'(vlane_addr), 64'(eq_a.pop_front()));
          chk({tag, " store_data"}, 64'(vlane_store_data), 64'(dat_a[eq_k.pop_front()]));
        end
        chk({tag, " dren"}, 64'(vmemdren), 64'(ld));
        chk({tag, " dwen"}, 64'(vmemdwen), 64'(!ld));
        chk({tag, " mode_flags"}, 64'({vindexed, strided, unit_strided}),
            64'({mode == 2, mode == 1, mode == 0}));
        chk({tag, " base_stride"}, {base, stride}, {b, s});
        chk({tag, " veew_seg"}, 64'({veew, vnew_seg, vseg_op}), 64'({2'(eew), 2'b00}));
        rcnt = 0;
        dtimer = 2;
        if (abort) begin
          @(negedge CLK);
          flush = 1'b1; ser_done = 1'b0;
          #1 chk({tag, " no_done_on_flush"}, 64'(done), 64'd0);
          @(negedge CLK);
          flush = 1'b0;
          #1 chk({tag, " flush_idle"}, 64'({busy, issue_ready, done}), 64'({1'b0, 1'b1, 1'b0}));
          fin = 1;
        end
      end
      if (done && !fin) begin
        ndone++;
        last_done_cyc = cyc;
        chk({tag, " ready_in_done"}, 64'(issue_ready), 64'd0);
        fin = 1;
      end
    end
    chk({tag, " finished"}, 64'(fin), 64'd1);
    last_nstart = nstart;
    if (!abort) begin
      chk({tag, " all_uops_launched"}, 64'(eq_k.size()), 64'd0);
      @(negedge CLK);
      #1 chk({tag, " single_done"}, 64'({done, busy}), 64'd0);
    end
    opnd_valid = 1'b0; ser_ready = 1'b0; ser_done = 1'b0;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++) begin
      v0_a[k]  = 2'($urandom);
      idx_a[k] = {$urandom, $urandom};
      dat_a[k] = {$urandom, $urandom};
    end
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_load = 1'b0; issue_vm = 1'b0;
    issue_mode = VMEM_UNIT; issue_veew = VSEW_8; issue_base = '0; issue_stride = '0; issue_vl = '0;
    opnd_valid = 1'b0; opnd_v0 = '0; opnd_index = '0; opnd_data = '0;
    ser_ready = 1'b0; ser_done = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset_ctrl", 64'({issue_ready, busy, done, opnd_req, ser_start}), 64'b10000);
    chk("reset_latch", 64'({vmemdwen, vmemdren, vindexed, strided, unit_strided, vuop_num}), 64'd0);
    chk("reset_lanes", vlane_addr | vlane_store_data | 64'(vlane_mask), 64'd0);

    fill_rand();
    run_instr("unit_ld", 1, 0, 2, 32'h1000, 32'h0, 5, 1, 0, 0);
    chk("unit_ld nstart", 64'(last_nstart), 64'd3);
    chk("unit_ld done_cyc", 64'(last_done_cyc), 64'd12);

    run_instr("strided_st", 0, 1, 0, 32'hFFFF_FFF0, 32'd8, 4, 1, 0, 0);
    chk("strided_st nstart", 64'(last_nstart), 64'd2);

    idx_a[0] = {32'h0000_0010, 32'h0003_8004};
    run_instr("indexed_ld", 1, 2, 1, 32'h2000, 32'h0, 2, 1, 0, 0);

    v0_a[0] = 2'b00; v0_a[1] = 2'b10;
    run_instr("masked", 1, 0, 2, 32'h4000, 32'h0, 4, 0, 0, 0);
    chk("masked nstart", 64'(last_nstart), 64'd1);
    chk("masked first_start", 64'(last_first_start), 64'd3);

    run_instr("vl0", 1, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
    chk("vl0 done_cyc", 64'(last_done_cyc), 64'd0);
    chk("vl0 nstart", 64'(last_nstart), 64'd0);

    run_instr("rdy_low", 0, 0, 1, 32'h8000, 32'h0, 2, 1, 6, 0);
    chk("rdy_low first_start", 64'(last_first_start), 64'd6);
    chk("rdy_low nstart", 64'(last_nstart), 64'd1);

    run_instr("flush", 1, 0, 2, 32'h100, 32'h0, 4, 1, 0, 1);
    run_instr("after_flush", 1, 1, 2, 32'h200, 32'd12, 3, 1, 0, 0);
    chk("after_flush nstart", 64'(last_nstart), 64'd2);

    run_instr("clamp", 0, 0, 0, 32'h0, 32'h0, 100, 1, 0, 0);
    chk("clamp nstart", 64'(last_nstart), 64'd32);

    for (int t = 0; t < 6; t++) begin
      fill_rand();
      run_instr("rand", 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                $urandom, $urandom, int'($urandom_range(0, 80)), 1'($urandom), int'($urandom_range(0, 3)), 0);
    end

    @(negedge CLK);
    issue_valid = 1'b1; issue_load = 1'b1; issue_mode = VMEM_UNIT; issue_veew = VSEW_32;
    issue_base = 32'h3000; issue_vl = 7'd6; issue_vm = 1'b1;
    @(negedge CLK);
    issue_valid = 1'b0; opnd_valid = 1'b0;
    #1 chk("rst_fetch opnd_req", 64'(opnd_req), 64'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_fetch ctrl", 64'({issue_ready, busy, done, opnd_req, ser_start}), 64'b10000);
    chk("rst_fetch latch", 64'({vmemdwen, vmemdren, vindexed, strided, unit_strided, vuop_num, opnd_uop}), 64'd0);
    chk("rst_fetch lanes", vlane_addr | vlane_store_data | 64'(vlane_mask) | 64'(base), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
